wm_cycle_sequencer: RTL

//  Parametrised washing-machine cycle sequencer: multi-coin pricing, internal phase timers,
//  N rinse passes, optional heat, lid-open pause/resume, fault counting with lockout.

---
 rtl/wm_cycle_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/wm_cycle_sequencer.sv
// Washing-machine cycle sequencer: coin pricing, phase timers, rinse passes, optional heat,
// lid-open pause/resume and fault counting with lockout, between sensor front end and drivers.
module wm_cycle_sequencer #(
  parameter  int TIMER_W      = 16,
  parameter  int PRICE_COINS  = 3,
  parameter  int FILL_TIMEOUT = 1000,
  parameter  int HEAT_TIMEOUT = 2000,
  parameter  int WASH_CYCLES  = 500,
  parameter  int RINSE_CYCLES = 300,
  parameter  int SPIN_CYCLES  = 400,
  parameter  int RINSE_PASSES = 2,
  parameter  int MAX_FAULTS   = 3,
  localparam int CREDIT_W     = $clog2(PRICE_COINS + 1),
  localparam int RINSE_W      = $clog2(RINSE_PASSES + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                sig_Coin,
  input  logic                sig_Cancel,
  input  logic                sig_Lid_Closed,
  input  logic                sig_Hot_Mode,
  input  logic                sig_Full,
  input  logic                sig_Temperature,
  input  logic                sig_Out_Of_Balance,
  input  logic                sig_Motor_Failure,
  output logic [3:0]          state,
  output logic [CREDIT_W-1:0] credit,
  output logic [RINSE_W-1:0]  rinse_Pass,
  output logic                water_Intake,
  output logic                heater_On,
  output logic                motor_Wash,
  output logic                motor_Spin,
  output logic                door_Lock,
  output logic                fault,
  output logic                coin_Return,
  output logic                done
);

  localparam int FAULT_W = $clog2(MAX_FAULTS + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_READY = 4'd1, S_FILL = 4'd2, S_HEAT = 4'd3, S_WASH = 4'd4,
    S_RINSE = 4'd5, S_SPIN = 4'd6, S_PAUSE = 4'd7, S_FAULT = 4'd8, S_LOCKOUT = 4'd9
  } state_t;

  state_t               cur;
  state_t               saved;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_inc;
  logic [FAULT_W-1:0]   fault_cnt;
  logic                 hot;

  // Saturating increment: the timer parks at all-ones instead of wrapping.
  assign timer_inc = (&timer) ? timer : timer + 1'b1;

  assign state        = cur;
  assign water_Intake = (cur == S_FILL) || (cur == S_RINSE);
  assign heater_On    = (cur == S_HEAT);
  assign motor_Wash   = (cur == S_WASH) || (cur == S_RINSE);
  assign motor_Spin   = (cur == S_SPIN);
  assign door_Lock    = ((cur >= S_FILL) && (cur <= S_SPIN)) || (cur == S_PAUSE);
  assign fault        = (cur == S_FAULT) || (cur == S_LOCKOUT);

  // NOTE: all state here is written with non-blocking assignments so every branch reads the
  // pre-edge values; later assignments in the block override the pulse defaults at the top.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur         <= S_IDLE;
      saved       <= S_IDLE;
      credit      <= '0;
      rinse_Pass  <= '0;
      timer       <= '0;
      fault_cnt   <= '0;
      hot         <= 1'b0;
      coin_Return <= 1'b0;
      done        <= 1'b0;
    end else begin
      coin_Return <= 1'b0;
      done        <= 1'b0;
      if (sig_Coin && cur != S_IDLE) coin_Return <= 1'b1;

      case (cur)
        S_IDLE: begin
          timer <= '0;
          if (sig_Cancel) begin
            if (credit != '0 || sig_Coin) coin_Return <= 1'b1;
            credit <= '0;
          end else if (sig_Coin) begin
            credit <= credit + 1'b1;
            if (credit == CREDIT_W'(PRICE_COINS - 1)) cur <= S_READY;
          end
        end

        S_READY: begin
          timer <= '0;
          if (sig_Cancel) begin
            cur         <= S_IDLE;
            credit      <= '0;
            fault_cnt   <= '0;
            coin_Return <= 1'b1;
          end else if (sig_Lid_Closed) begin
            cur        <= S_FILL;
            hot        <= sig_Hot_Mode;
            rinse_Pass <= '0;
          end
        end

        S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN: begin
          timer <= timer_inc;
          if (sig_Cancel) begin
            cur       <= S_IDLE;
            credit    <= '0;
            fault_cnt <= '0;
            timer     <= '0;
          end else if (!sig_Lid_Closed) begin
            // Timer is frozen, not cleared, so the phase resumes where it stopped.
            saved <= cur;
            cur   <= S_PAUSE;
            timer <= timer;
          end else begin
            case (cur)
              S_FILL: begin
                if (sig_Full) begin
                  cur   <= hot ? S_HEAT : S_WASH;
                  timer <= '0;
                end else if (timer == TIMER_W'(FILL_TIMEOUT - 1)) begin
                  cur   <= S_FAULT;
                  timer <= '0;
                end
              end
              S_HEAT: begin
                if (sig_Temperature) begin
                  cur   <= S_WASH;
                  timer <= '0;
                end else if (timer == TIMER_W'(HEAT_TIMEOUT - 1)) begin
                  cur   <= S_FAULT;
                  timer <= '0;
                end
              end
              S_WASH: begin
                if (timer == TIMER_W'(WASH_CYCLES - 1)) begin
                  cur   <= S_RINSE;
                  timer <= '0;
                end else if (sig_Out_Of_Balance) begin
                  cur   <= S_FAULT;
                  timer <= '0;
                end
              end
              S_RINSE: begin
                if (timer == TIMER_W'(RINSE_CYCLES - 1)) begin
                  rinse_Pass <= rinse_Pass + 1'b1;
                  timer      <= '0;
                  if (rinse_Pass == RINSE_W'(RINSE_PASSES - 1)) cur <= S_SPIN;
                end else if (sig_Motor_Failure) begin
                  cur   <= S_FAULT;
                  timer <= '0;
                end
              end
              S_SPIN: begin
                if (timer == TIMER_W'(SPIN_CYCLES - 1)) begin
                  cur       <= S_IDLE;
                  done      <= 1'b1;
                  credit    <= '0;
                  fault_cnt <= '0;
                  timer     <= '0;
                end else if (sig_Motor_Failure || sig_Out_Of_Balance) begin
                  cur   <= S_FAULT;
                  timer <= '0;
                end
              end
              default: ;
            endcase
          end
        end

        S_PAUSE: begin
          if (sig_Cancel) begin
            cur       <= S_IDLE;
            credit    <= '0;
            fault_cnt <= '0;
            timer     <= '0;
          end else if (sig_Lid_Closed) begin
            cur <= saved;
          end
        end

        S_FAULT: begin
          timer     <= '0;
          fault_cnt <= fault_cnt + 1'b1;
          cur       <= (fault_cnt == FAULT_W'(MAX_FAULTS - 1)) ? S_LOCKOUT : S_READY;
        end

        S_LOCKOUT: begin
          timer <= '0;
          if (sig_Cancel) coin_Return <= 1'b1;
        end

        default: begin
          cur   <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
